counter_command_scheduler: RTL
==============================

COUNTER_COMMAND_SCHEDULER -- requirements
Module: counter_command_scheduler

Interface
REQ-001 Parameter DELAY_TICKS, default 8, is the number of ticks from a first-press command to the first auto-repeat command.
REQ-002 Parameter RATE_TICKS, default 2, is the number of ticks between successive auto-repeat commands.
REQ-003 Parameter TIMER_BITS, default 4, is the width of the repeat timer and SHALL satisfy 2^TIMER_BITS >= max(DELAY_TICKS, RATE_TICKS).
REQ-004 clock  input  1  single block clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  one-clock-wide enable pulse from the debouncing-rate scaler; inputs are sampled only when tick=1.
REQ-007 upPressed  input  1  debounced up-button level.
REQ-008 downPressed  input  1  debounced down-button level.
REQ-009 loadPressed  input  1  debounced load-button level.
REQ-010 switches  input  4  load value source.
REQ-011 cmdUp  output  1  one-clock increment pulse to the up/down counter.
REQ-012 cmdDown  output  1  one-clock decrement pulse to the up/down counter.
REQ-013 cmdLoad  output  1  one-clock load pulse to the up/down counter.
REQ-014 loadValue  output  4  registered switches captured on the sample that issued cmdLoad.
REQ-015 repeating  output  1  high while the FSM is in REPEAT.

Function
REQ-016 The FSM states SHALL be IDLE, HOLD, REPEAT and LOCKOUT, and transitions SHALL be evaluated only on cycles with tick=1.
REQ-017 A decision made on a tick cycle SHALL produce its command pulse in the following clock cycle, for exactly one cycle.
REQ-018 cmdUp, cmdDown and cmdLoad SHALL be mutually exclusive in every cycle.
REQ-019 Priority SHALL be: load first; then up XOR down; up and down together is a conflict.
REQ-020 IDLE transitions:
- loadPressed: issue cmdLoad, capture switches, go to LOCKOUT.
- Exactly one of up/down: issue that command, latch the direction, set timer to DELAY_TICKS-1, go to HOLD.
- Both up and down: no command, go to LOCKOUT.
- None pressed: stay in IDLE.
REQ-021 HOLD/REPEAT transitions:
- loadPressed: issue cmdLoad, capture switches, go to LOCKOUT.
- Latched button released or opposite button pressed: no command; go to IDLE if no button is pressed, else go to LOCKOUT.
- Timer = 0: issue the latched-direction command, set timer to RATE_TICKS-1, go to REPEAT.
- Otherwise: decrement timer.
REQ-022 LOCKOUT SHALL issue no commands and SHALL return to IDLE on the first tick where up, down and load are all 0.
REQ-023 loadValue SHALL hold its value between loads.
REQ-024 The timer SHALL never wrap; it is reloaded only on command issue.
REQ-025 tick=0 SHALL freeze state, timer and the latched direction.

Reset
REQ-026 While reset=1 on a clock edge, the block SHALL force state=IDLE, timer=0, direction=up and all outputs to 0, overriding tick.
REQ-027 Reset asserted in the cycle a command pulse is pending SHALL suppress that pulse.
REQ-028 A button still held after reset deasserts SHALL be treated as a fresh first press on the next tick.

Structure
REQ-029 The state encoding, the command constants and the default parameter values SHALL live in a shared package/header used by this block and the counter top level.
REQ-030 The repeat timer (load, decrement-on-tick, zero flag) SHALL be one sub-module, repeattimer.
REQ-031 The block SHALL drive the existing up/down counter directly; no combinational path SHALL exist from the inputs to the cmd outputs.

Verification (DELAY_TICKS=4, RATE_TICKS=2)
REQ-032 Up held for 1 tick, then released -> exactly one cmdUp pulse, in the cycle after that tick.
REQ-033 Up held for ticks 0..9 -> cmdUp after ticks 0, 4, 6 and 8 only; repeating=1 from the tick-4 decision onward.
REQ-034 switches=4'hA with load and up pressed together -> cmdLoad with loadValue=4'hA; no cmdUp while up stays held; normal operation resumes after all buttons are released.
REQ-035 Up and down pressed together for 5 ticks -> no command; after release, a down press yields one cmdDown.
REQ-036 Reset pulse during REPEAT with up still held -> outputs 0 after the edge; one fresh cmdUp on the next tick; the next repeat comes 4 ticks later.
REQ-037 tick held at 0 for 100 cycles with all buttons toggling -> no command pulses and no state change.

Source files
------------

// File: rtl/counter_command_scheduler_pkg.sv
// Shared definitions for the button command scheduler and the counter top level:
// FSM encoding, command codes, direction values and default timing parameters.
package counter_command_scheduler_pkg;

    localparam int DEF_DELAY_TICKS = 8;
    localparam int DEF_RATE_TICKS  = 2;
    localparam int DEF_TIMER_BITS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_LOCKOUT
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_UP,
        CMD_DOWN,
        CMD_LOAD
    } cmd_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic cmd_t dir_cmd(input logic dir);
        return (dir == DIR_DOWN) ? CMD_DOWN : CMD_UP;
    endfunction

endpackage

// File: rtl/counter_command_scheduler_if.sv
// Button-side inputs and counter-side command outputs of the scheduler.
interface counter_command_scheduler_if;
    logic       tick;
    logic       upPressed;
    logic       downPressed;
    logic       loadPressed;
    logic [3:0] switches;
    logic       cmdUp;
    logic       cmdDown;
    logic       cmdLoad;
    logic [3:0] loadValue;
    logic       repeating;

    modport master (
        output tick, upPressed, downPressed, loadPressed, switches,
        input  cmdUp, cmdDown, cmdLoad, loadValue, repeating
    );

    modport slave (
        input  tick, upPressed, downPressed, loadPressed, switches,
        output cmdUp, cmdDown, cmdLoad, loadValue, repeating
    );
endinterface

// File: rtl/counter_command_scheduler_repeattimer.sv
// Auto-repeat down-counter: reload on command issue, decrement on enabled ticks,
// saturates at zero instead of wrapping.
module counter_command_scheduler_repeattimer #(
    parameter int TIMER_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [TIMER_BITS-1:0] load_value,
    input  logic                  dec,
    output logic                  zero
);

    logic [TIMER_BITS-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - TIMER_BITS'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/counter_command_scheduler.sv
// Turns debounced button levels into one-cycle up/down/load pulses for the
// up/down counter, with hold-to-auto-repeat and a lockout after loads/conflicts.
module counter_command_scheduler
    import counter_command_scheduler_pkg::*;
#(
    parameter int DELAY_TICKS = DEF_DELAY_TICKS,
    parameter int RATE_TICKS  = DEF_RATE_TICKS,
    parameter int TIMER_BITS  = DEF_TIMER_BITS
) (
    input  logic                         clock,
    input  logic                         reset,
    counter_command_scheduler_if.slave   bus
);

    state_t     state_d, state_q;
    cmd_t       cmd_d, cmd_q;
    logic       dir_d, dir_q;
    logic [3:0] load_value_d, load_value_q;

    logic                  tmr_load;
    logic [TIMER_BITS-1:0] tmr_load_value;
    logic                  tmr_dec;
    logic                  tmr_zero;
    logic                  held_latched;
    logic                  held_opposite;
    logic                  any_dir;

    assign held_latched  = (dir_q == DIR_DOWN) ? bus.downPressed : bus.upPressed;
    assign held_opposite = (dir_q == DIR_DOWN) ? bus.upPressed   : bus.downPressed;
    assign any_dir       = bus.upPressed | bus.downPressed;

    counter_command_scheduler_repeattimer #(
        .TIMER_BITS (TIMER_BITS)
    ) repeattimer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_d        = state_q;
        cmd_d          = CMD_NONE;
        dir_d          = dir_q;
        load_value_d   = load_value_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        tmr_dec        = 1'b0;
        if (bus.tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.loadPressed) begin
                        cmd_d        = CMD_LOAD;
                        load_value_d = bus.switches;
                        state_d      = ST_LOCKOUT;
                    end else if (bus.upPressed ^ bus.downPressed) begin
                        dir_d          = bus.downPressed ? DIR_DOWN : DIR_UP;
                        cmd_d          = dir_cmd(dir_d);
                        tmr_load       = 1'b1;
                        tmr_load_value = TIMER_BITS'(DELAY_TICKS - 1);
                        state_d        = ST_HOLD;
                    end else if (bus.upPressed && bus.downPressed) begin
                        state_d = ST_LOCKOUT;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (bus.loadPressed) begin
                        cmd_d        = CMD_LOAD;
                        load_value_d = bus.switches;
                        state_d      = ST_LOCKOUT;
                    end else if (!held_latched || held_opposite) begin
                        // Released or contested: wait for a clean all-released tick
                        state_d = any_dir ? ST_LOCKOUT : ST_IDLE;
                    end else if (tmr_zero) begin
                        cmd_d          = dir_cmd(dir_q);
                        tmr_load       = 1'b1;
                        tmr_load_value = TIMER_BITS'(RATE_TICKS - 1);
                        state_d        = ST_REPEAT;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (!any_dir && !bus.loadPressed) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= CMD_NONE;
            dir_q        <= DIR_UP;
            load_value_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            dir_q        <= dir_d;
            load_value_q <= load_value_d;
        end
    end

    assign bus.cmdUp     = (cmd_q == CMD_UP);
    assign bus.cmdDown   = (cmd_q == CMD_DOWN);
    assign bus.cmdLoad   = (cmd_q == CMD_LOAD);
    assign bus.loadValue = load_value_q;
    assign bus.repeating = (state_q == ST_REPEAT);

endmodule
